alu_op_sequencer: RTL

- Sequential initiator for the combinational ALU: accepts one operation request at a time over a valid/ready handshake and owns the ACC, BR and IR holding registers.
- Issues exactly one one-hot ALU control strobe (C8..C21) for one cycle, then writes the ALU result back into ACC and the flags into FLAGS.
- Returns result, flags and error over a valid/ready response channel. Sits between the instruction front end and the ALU.

---
 rtl/alu_op_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Sequencer for the 16-bit combinational ALU: owns ACC/BR/IR/FLAGS, fires one control strobe per op.
// Optional macro ALU_SEQ_DIVZ_TRAP_EN traps divide-by-zero (ACC kept, rsp_err raised).
module alu_op_sequencer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [W-1:0] req_operand,
    input  logic [3:0]   req_shamt,
    output logic         C8,
    output logic         C9,
    output logic         C13,
    output logic         C15,
    output logic         C16,
    output logic         C17,
    output logic         C18,
    output logic         C19,
    output logic         C20,
    output logic         C21,
    output logic [W-1:0] ACC_out,
    output logic [W-1:0] BR_out,
    output logic [W-1:0] IR_out,
    input  logic [W-1:0] ALU_out,
    input  logic [3:0]   ALUflags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_t;

    typedef enum logic [3:0] {
        OP_CLR, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL,
        OP_SHR, OP_AND, OP_OR,  OP_NOT, OP_LDA, OP_NOP
    } op_t;

    state_t       state;
    state_t       next_state;
    logic [3:0]   op_q;
    logic [W-1:0] acc;
    logic [W-1:0] br;
    logic [W-1:0] ir;
    logic [3:0]   flags;
    logic         err;
    logic [9:0]   strobe;
    logic         req_legal;

    assign req_legal = (req_op < 4'd12);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobe bit index equals the opcode for CLR..NOT, so a shift decodes it.
    always_comb begin
        next_state = state;
        strobe     = 10'd0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = req_legal ? LOAD : RESP;
                end
            end
            LOAD: next_state = EXEC;
            EXEC: begin
                next_state = RESP;
                if (op_q < 4'd10) begin
                    strobe = 10'd1 << op_q;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_NOP;
            acc   <= '0;
            br    <= '0;
            ir    <= '0;
            flags <= 4'b1000;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_legal) begin
                            op_q <= req_op;
                            br   <= req_operand;
                            ir   <= {{(W-4){1'b0}}, req_shamt};
                            err  <= 1'b0;
                        end else begin
                            err  <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_LDA: begin
                            acc   <= br;
                            flags <= {(br == '0), 2'b00, br[W-1]};
                        end
                        OP_NOP: ;
`ifdef ALU_SEQ_DIVZ_TRAP_EN
                        OP_DIV: begin
                            flags <= ALUflags;
                            if (br == '0) begin
                                err <= 1'b1;
                            end else begin
                                acc <= ALU_out;
                            end
                        end
`else
                        OP_DIV: begin
                            acc   <= ALU_out;
                            flags <= ALUflags;
                        end
`endif
                        default: begin
                            acc   <= ALU_out;
                            flags <= ALUflags;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign {C21, C20, C19, C18, C17, C16, C15, C13, C9, C8} = strobe;

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == RESP);
    assign rsp_result = acc;
    assign rsp_flags  = flags;
    assign rsp_err    = err;
    assign ACC_out    = acc;
    assign BR_out     = br;
    assign IR_out     = ir;

endmodule
